usr_cmd_sequencer: RTL and testbench
====================================

USR_CMD_SEQUENCER -- requirements
Module: usr_cmd_sequencer

Interface
REQ-001 Parameter BITS, default 8: width of the data operand driven to the shift register.
REQ-002 Parameter DEPTH, default 4: command FIFO depth, power of two.
REQ-003 clk  in  1: single clock; all state changes on the rising edge.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each: Wishbone classic slave strobe, cycle and write-enable inputs.
REQ-006 wbs_adr_i  in  32: byte address; only bits [3:2] are decoded.
REQ-007 wbs_dat_i  in  32: write data.
REQ-008 wbs_ack_o  out  1: single-cycle acknowledge.
REQ-009 wbs_dat_o  out  32: read data.
REQ-010 dataOut  out  BITS: operand for the downstream universal shift register.
REQ-011 ctrlOut  out  2: operation code (00 load, 01 right, 10 left, 11 serial).
REQ-012 cmdValid  out  1: high in every cycle where dataOut/ctrlOut carry an executing command.
REQ-013 busy  out  1: high when the FSM is in RUN or the FIFO is non-empty.

Function
REQ-014 Register map: 0x0 CMD (write-only), 0x4 STATUS (read-only), 0x8 CTRL (write-only); unmapped reads return 0; unmapped writes are ignored.
REQ-015 CMD word: [BITS-1:0] data, [9:8] ctrl, [15:12] rep; the command executes for rep+1 consecutive cycles.
REQ-016 STATUS word: [3:0] FIFO level (0..DEPTH), [8] busy, [9] overflow (sticky), [10] full, [11] empty; other bits 0.
REQ-017 CTRL write: bit0=1 flushes; bit1=1 clears overflow; the two bits act independently in the same write.
REQ-018 Wishbone timing: wbs_ack_o rises the cycle after stb&cyc while ack is low, and stays high for exactly one cycle.
REQ-019 Wishbone throughput: the minimum spacing between two accepted transfers is 2 cycles.
REQ-020 A write side effect commits on the edge that raises ack; every access is acked, including dropped writes.
REQ-021 CMD write when full: command dropped, overflow set; fullness is evaluated before a same-edge pop.
REQ-022 FSM states: IDLE, RUN.
REQ-023 IDLE: when the FIFO is non-empty, pop the head, load cur={data,ctrl}, load cnt=rep, and go to RUN.
REQ-024 RUN: cmdValid=1; while cnt>0, decrement cnt each cycle.
REQ-025 RUN exit at cnt==0: if the FIFO is non-empty, pop the next command back-to-back with no gap; otherwise go to IDLE.
REQ-026 Latency: a CMD write acked in cycle T makes cmdValid=1 in cycle T+2 when the FSM was idle.
REQ-027 In IDLE, cmdValid=0; dataOut and ctrlOut hold their last values.
REQ-028 Flush: empties the FIFO and forces IDLE, so cmdValid=0 from the next cycle; flush wins over a same-edge pop.
REQ-029 FIFO pointers wrap modulo DEPTH; the level counter saturates neither at 0 nor at DEPTH because push and pop are gated by empty/full.

Reset
REQ-030 Reset values: FIFO empty, FSM IDLE, cnt=0, overflow=0, dataOut=0, ctrlOut=00, cmdValid=0, busy=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-031 Reset asserted mid-command aborts that command immediately and discards all queued commands.

Structure
REQ-032 Shared package usr_pkg: register offsets, CMD/STATUS bit-field positions, ctrl opcode constants, FSM state encoding.
REQ-033 The FIFO is one sub-module, usr_cmd_fifo, with push/pop/flush, full/empty and level outputs.

Verification
REQ-034 Write CMD 0x0000_00A5 (load, rep 0): exactly 1 cycle of cmdValid=1 with dataOut=0xA5 and ctrlOut=00, starting 2 cycles after ack.
REQ-035 Write CMD 0x0000_3101 (right, rep 3): cmdValid=1 for 4 cycles with ctrlOut=01; STATUS then reads busy=0, empty=1.
REQ-036 Queue 3 commands: each runs for rep+1 cycles, back-to-back with no cmdValid gap.
REQ-037 5 CMD writes while the first executes: the 5th is dropped and STATUS shows overflow=1, level=4.
REQ-038 Write CTRL=0x2 after the overflow scenario: STATUS overflow reads 0.
REQ-039 Write CTRL=0x1 during a rep-15 command: cmdValid=0 the next cycle and STATUS level=0.
REQ-040 Assert reset mid-RUN with 2 commands queued: all outputs return to reset values asynchronously and no queued command executes afterwards.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the user command sequencer:
//   - Wishbone register offsets (decoded from address bits [3:2])
//   - CMD / STATUS / CTRL word bit-field positions
//   - shift-register opcode constants
//   - FSM state encoding
package usr_pkg;

  // Register offsets, expressed as word index (byte address bits [3:2]).
  localparam logic [1:0] ADDR_CMD    = 2'd0;  // 0x0, write-only
  localparam logic [1:0] ADDR_STATUS = 2'd1;  // 0x4, read-only
  localparam logic [1:0] ADDR_CTRL   = 2'd2;  // 0x8, write-only

  // CMD word layout: [BITS-1:0] data, [9:8] ctrl, [15:12] rep.
  localparam int CMD_CTRL_LSB = 8;
  localparam int CMD_REP_LSB  = 12;
  localparam int REP_W        = 4;

  // STATUS word layout: [3:0] level, [8] busy, [9] overflow, [10] full, [11] empty.
  localparam int STAT_LEVEL_W  = 4;
  localparam int STAT_BUSY_BIT = 8;
  localparam int STAT_OVF_BIT  = 9;
  localparam int STAT_FULL_BIT = 10;
  localparam int STAT_EMPTY_BIT = 11;

  // CTRL word bits.
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Universal shift register opcodes.
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_RIGHT  = 2'b01;
  localparam logic [1:0] OP_LEFT   = 2'b10;
  localparam logic [1:0] OP_SERIAL = 2'b11;

  // FSM state encoding.
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

endpackage

// File: rtl/usr_cmd_fifo.sv
// Command FIFO for the sequencer.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_data (ignored while full)
//   push_data   : entry to store
//   pop         : advance the read pointer (ignored while empty)
//   flush       : empty the FIFO; wins over a same-edge push or pop
//   head        : entry at the read pointer
//   full, empty : occupancy flags
//   level       : number of stored entries, 0..DEPTH
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module usr_cmd_fifo
  import usr_pkg::*;
#(
  parameter int W     = 14,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // Fullness/emptiness are judged on the pre-edge level, so a push into a
  // full FIFO is dropped even if a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the level counter alone decides
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Wishbone-programmed command sequencer for a universal shift register.
//   clk, reset            : clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i  : Wishbone classic slave controls
//   wbs_adr_i             : byte address, bits [3:2] decoded
//   wbs_dat_i / wbs_dat_o : write / read data
//   wbs_ack_o             : one-cycle acknowledge
//   dataOut, ctrlOut      : operand and opcode of the executing command
//   cmdValid              : dataOut/ctrlOut carry an executing command
//   busy                  : FSM in RUN or commands still queued
// Commands are queued in usr_cmd_fifo and each runs for rep+1 cycles.
// The shift-register outputs are registered from the FSM's current command,
// giving a two-cycle write-ack to cmdValid latency.
module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [BITS-1:0] dataOut,
  output logic [1:0]      ctrlOut,
  output logic            cmdValid,
  output logic            busy
);

  localparam int W  = BITS + 2 + REP_W;
  localparam int LW = $clog2(DEPTH + 1);

  logic            access;
  logic            wr_cmd;
  logic            wr_ctrl;
  logic            flush;
  logic            clr_ovf;
  logic            pop;
  logic [W-1:0]    push_data;
  logic [W-1:0]    head;
  logic            full;
  logic            empty;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [31:0]     status_word;
  logic [31:0]     rdata;
  logic [0:0]      state;
  logic [REP_W-1:0] cnt;
  logic [BITS-1:0] cur_data;
  logic [1:0]      cur_ctrl;
  logic            unused_bits;

  // A transfer is accepted only while ack is low, which spaces accepted
  // transfers at least two cycles apart.
  assign access  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_cmd  = access & wbs_we_i & (wbs_adr_i[3:2] == ADDR_CMD);
  assign wr_ctrl = access & wbs_we_i & (wbs_adr_i[3:2] == ADDR_CTRL);
  assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH_BIT];
  assign clr_ovf = wr_ctrl & wbs_dat_i[CTRL_CLR_OVF_BIT];

  assign push_data = {wbs_dat_i[BITS-1:0],
                      wbs_dat_i[CMD_CTRL_LSB +: 2],
                      wbs_dat_i[CMD_REP_LSB +: REP_W]};

  // Pop in IDLE, or on the last cycle of RUN for a gapless hand-over.
  // Flush suppresses the pop.
  assign pop  = ~flush & ~empty & ((state == STATE_IDLE) || (cnt == '0));
  assign busy = (state == STATE_RUN) | ~empty;

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0],
                         wbs_dat_i[31:16], wbs_dat_i[11:10]};

  usr_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_cmd),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    status_word                            = '0;
    status_word[STAT_LEVEL_W-1:0]          = STAT_LEVEL_W'(level);
    status_word[STAT_BUSY_BIT]             = busy;
    status_word[STAT_OVF_BIT]              = overflow;
    status_word[STAT_FULL_BIT]             = full;
    status_word[STAT_EMPTY_BIT]            = empty;
    rdata                                  = '0;
    if (wbs_adr_i[3:2] == ADDR_STATUS) rdata = status_word;
  end

  // Wishbone slave: ack and read data register on the accepting edge, which
  // is also where write side effects commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      overflow  <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
      if (wr_cmd && full) overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

  // Sequencer FSM: holds the current command and its remaining repeat count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= STATE_IDLE;
      cnt      <= '0;
      cur_data <= '0;
      cur_ctrl <= OP_LOAD;
    end else if (flush) begin
      state <= STATE_IDLE;
      cnt   <= '0;
    end else if (pop) begin
      cur_data <= head[W-1 -: BITS];
      cur_ctrl <= head[REP_W +: 2];
      cnt      <= head[REP_W-1:0];
      state    <= STATE_RUN;
    end else if (state == STATE_RUN) begin
      if (cnt != '0) cnt   <= cnt - 1'b1;
      else           state <= STATE_IDLE;
    end
  end

  // Output stage: follows the FSM one cycle later; outside RUN the operand
  // and opcode hold their last values. Flush drops cmdValid immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmdValid <= 1'b0;
      dataOut  <= '0;
      ctrlOut  <= OP_LOAD;
    end else begin
      cmdValid <= ~flush & (state == STATE_RUN);
      if (!flush && state == STATE_RUN) begin
        dataOut <= cur_data;
        ctrlOut <= cur_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed testbench for usr_cmd_sequencer.
module tb_usr_cmd_sequencer;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_we_i = 1'b0;
  logic [31:0]     wbs_adr_i = '0;
  logic [31:0]     wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [BITS-1:0] dataOut;
  logic [1:0]      ctrlOut;
  logic            cmdValid;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usr_cmd_sequencer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .dataOut   (dataOut),
    .ctrlOut   (ctrlOut),
    .cmdValid  (cmdValid),
    .busy      (busy)
  );

  // One Wishbone transfer. Returns on the falling edge of the ack cycle.
  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (wbs_ack_o !== 1'b1 && n < 4);
    n_checks++;
    if (wbs_ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_timeout adr=%h: ack=%b, required 1 within 4 cycles", adr, wbs_ack_o);
    end
    rdata = wbs_dat_o;
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_access(1'b1, adr, dat, dummy);
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, 32'h4, 32'h0, r);
    n_checks++;
    if (r !== exp) begin
      n_fail++;
      $display("FAIL %s: status=%h, required %h", name, r, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || cmdValid !== 1'b0) && n < 100) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (busy !== 1'b0 || cmdValid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b cmdValid=%b, required 0 0", name, busy, cmdValid);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({cmdValid, busy, wbs_ack_o, ctrlOut, dataOut, wbs_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cmdValid=%b busy=%b ack=%b ctrl=%b data=%h dat_o=%h, required all 0",
               cmdValid, busy, wbs_ack_o, ctrlOut, dataOut, wbs_dat_o);
    end
    check_status("reset_status", 32'h0000_0800);
  endtask

  // Holding stb/cyc high must give ack 1,0,1,0: one-cycle ack, 2-cycle spacing.
  task automatic test_ack();
    logic exp;
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = (i % 2 == 0);
      n_checks++;
      if (wbs_ack_o !== exp) begin
        n_fail++;
        $display("FAIL ack_pattern[%0d]: ack=%b, required %b", i, wbs_ack_o, exp);
      end
    end
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    begin
      logic [31:0] r;
      wb_access(1'b0, 32'hC, 32'h0, r);
      n_checks++;
      if (r !== 32'h0) begin
        n_fail++;
        $display("FAIL unmapped_read: data=%h, required 00000000", r);
      end
    end
  endtask

  task automatic test_single();
    logic exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    wb_write(32'h0, 32'h0000_00A5);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (cmdValid !== exp_v[k]) begin
        n_fail++;
        $display("FAIL single_valid[T+%0d]: cmdValid=%b, required %b", k, cmdValid, exp_v[k]);
      end
      if (k == 2 || k == 4) begin
        n_checks++;
        if (dataOut !== 8'hA5 || ctrlOut !== 2'b00) begin
          n_fail++;
          $display("FAIL single_data[T+%0d]: data=%h ctrl=%b, required a5 00", k, dataOut, ctrlOut);
        end
      end
    end
    wait_idle("single");
  endtask

  task automatic test_rep();
    logic exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    wb_write(32'h0, 32'h0000_3101);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (cmdValid !== exp_v[k] || (exp_v[k] && (ctrlOut !== 2'b01 || dataOut !== 8'h01))) begin
        n_fail++;
        $display("FAIL rep_cycle[T+%0d]: cmdValid=%b ctrl=%b data=%h, required %b 01 01",
                 k, cmdValid, ctrlOut, dataOut, exp_v[k]);
      end
    end
    check_status("rep_status_idle", 32'h0000_0800);
  endtask

  // Three queued commands (5, 3 and 2 cycles) must run with no gap.
  task automatic test_back_to_back();
    logic       s_v [16];
    logic [7:0] s_d [16];
    logic [1:0] s_c [16];
    logic       e_v;
    logic [7:0] e_d;
    logic [1:0] e_c;
    fork
      begin
        wb_write(32'h0, 32'h0000_4111);
        wb_write(32'h0, 32'h0000_2222);
        wb_write(32'h0, 32'h0000_1333);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          s_v[i] = cmdValid; s_d[i] = dataOut; s_c[i] = ctrlOut;
        end
      end
    join
    // First write acks in sample 1, so cmdValid starts at sample 3.
    for (int i = 0; i < 16; i++) begin
      e_v = (i >= 3 && i <= 12);
      e_d = (i <= 7) ? 8'h11 : (i <= 10) ? 8'h22 : 8'h33;
      e_c = (i <= 7) ? 2'b01 : (i <= 10) ? 2'b10 : 2'b11;
      n_checks++;
      if (s_v[i] !== e_v || (e_v && (s_d[i] !== e_d || s_c[i] !== e_c))) begin
        n_fail++;
        $display("FAIL b2b[%0d]: cmdValid=%b data=%h ctrl=%b, required %b %h %b",
                 i, s_v[i], s_d[i], s_c[i], e_v, e_d, e_c);
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_overflow();
    wb_write(32'h0, 32'h0000_F0A0);        // rep 15, runs while the rest queue
    for (int i = 1; i <= 5; i++) wb_write(32'h0, 32'h0000_0000 | i);
    // level 4, busy, overflow, full
    check_status("overflow_status", 32'h0000_0704);
    wb_write(32'h8, 32'h0000_0002);
    begin
      logic [31:0] r;
      wb_access(1'b0, 32'h4, 32'h0, r);
      n_checks++;
      if (r[9] !== 1'b0 || r[8] !== 1'b1) begin
        n_fail++;
        $display("FAIL overflow_clear: ovf=%b busy=%b, required 0 1", r[9], r[8]);
      end
    end
    wait_idle("overflow");
    check_status("overflow_drained", 32'h0000_0800);
  endtask

  task automatic test_flush();
    int highs = 0;
    wb_write(32'h0, 32'h0000_F2AA);
    wb_write(32'h0, 32'h0000_0055);
    repeat (3) @(negedge clk);
    wb_write(32'h8, 32'h0000_0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmdValid !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL flush_valid: cmdValid high in %0d cycles after flush, required 0", highs);
    end
    check_status("flush_status", 32'h0000_0800);
  endtask

  task automatic test_reset_mid_run();
    int highs = 0;
    wb_write(32'h0, 32'h0000_F0C3);
    wb_write(32'h0, 32'h0000_0011);
    wb_write(32'h0, 32'h0000_0022);
    @(negedge clk);
    n_checks++;
    if (cmdValid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_running: cmdValid=%b, required 1", cmdValid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({cmdValid, busy, wbs_ack_o, ctrlOut, dataOut, wbs_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: cmdValid=%b busy=%b ack=%b ctrl=%b data=%h dat_o=%h, required all 0",
               cmdValid, busy, wbs_ack_o, ctrlOut, dataOut, wbs_dat_o);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmdValid !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) begin
      n_fail++;
      $display("FAIL reset_discard: cmdValid high in %0d cycles after reset, required 0", highs);
    end
    check_status("reset_mid_status", 32'h0000_0800);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_ack();
    test_single();
    test_rep();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
